cnn_mac_seq: RTL and testbench
==============================

CNN_MAC_SEQ -- requirements
Module: cnn_mac_seq

Interface
REQ-001 Parameter LEN_W, default 8: width of the length input and of both memory address ports.
REQ-002 Parameter ACC_W, default 29: signed accumulator width; exact for 255 terms of 14s x 7u, no wrap.
REQ-003 ap_clk  in  1  single clock, all state on rising edge.
REQ-004 ap_rst  in  1  reset, synchronous, active-high.
REQ-005 ap_start  in  1  start request, sampled only in IDLE.
REQ-006 ap_done / ap_idle / ap_ready  out  1 each  block-level handshake.
REQ-007 len  in  LEN_W  dot-product length N (0..255), latched on accepted start.
REQ-008 a_address0 / a_ce0 / a_q0  out LEN_W / out 1 / in 14  activation ROM port, signed Q6.8, 1-cycle read latency.
REQ-009 b_address0 / b_ce0 / b_q0  out LEN_W / out 1 / in 7  weight ROM port, unsigned U0.7, 1-cycle read latency.
REQ-010 ap_return  out  14  signed Q6.8 result.
REQ-011 sat  out  1  result was saturated.

Function
REQ-012 FSM states IDLE, RUN, DRAIN, DONE; ap_idle=1 only in IDLE.
REQ-013 IDLE: ap_start=1 at cycle 0 -> latch N, clear accumulator, go RUN (N>0) or DONE (N=0).
REQ-014 RUN: cycles 1..N issue address k=0..N-1 on both ports, a_ce0=b_ce0=1, one address per cycle (II=1); ce low in every other state.
REQ-015 ap_ready=1 for exactly one cycle, the cycle the last address (N-1) is issued; for N=0, in the DONE cycle.
REQ-016 Pipeline: ROM data cycle k+2, registered 21-bit product (a signed * {0,b}) cycle k+3, accumulate into ACC_W bits same cycle; RUN -> DRAIN after last issue, DRAIN lasts 2 cycles -> DONE.
REQ-017 DONE at cycle N+3 (N>0) or 1 (N=0): ap_done=1 for one cycle, ap_return/sat valid and held until the next accepted start; DONE -> IDLE unconditionally.
REQ-018 Result: acc arithmetic-shifted right by 7 (floor), saturated to [-8192, 8191]; sat=1 iff clamped; N=0 gives 0, sat=0.
REQ-019 ap_start while not in IDLE is ignored; ap_start held high restarts in the IDLE cycle after DONE.
REQ-020 len changes after acceptance have no effect on the running operation.

Reset
REQ-021 ap_rst=1 at any cycle, including mid-RUN/DRAIN: next state IDLE, accumulator 0, ap_return=0, sat=0, ap_done=ap_ready=0, ap_idle=1, ce=0, addresses 0; in-flight products discarded.

Structure
REQ-022 Package cnn_mac_pkg holds: state enum, A_W=14, B_W=7, P_W=21, FRAC_SHIFT=7, OUT_MAX=8191, OUT_MIN=-8192.
REQ-023 One sub-module cnn_mac_seq_mul: combinational 14s x 7u -> 21s multiply (zero-extended b), mapped to DSP; registering is done in cnn_mac_seq.

Verification
REQ-024 N=4, a=256 all, b=64 all -> products 16384, acc 65536, ap_return=512, sat=0, ap_ready cycle 4, ap_done cycle 7.
REQ-025 N=0 -> ap_done and ap_ready cycle 1, ap_return=0, no ce pulse.
REQ-026 N=255, a=8191, b=127 -> ap_return=8191, sat=1; a=-8192, b=127 -> ap_return=-8192, sat=1.
REQ-027 N=1, a=-1, b=1 -> ap_return=-1 (floor), sat=0; a=1, b=1 -> 0.
REQ-028 N=10, ap_rst at cycle 3 -> next cycle ap_idle=1, ce=0, ap_return=0; then N=1, a=128, b=127 -> ap_return=127.
REQ-029 ap_start pulsed during RUN ignored; ap_start held high over two N=2 ops -> second accepted the IDLE cycle after first ap_done, both results correct.

Source files
------------

// File: rtl/cnn_mac_pkg.sv
// Shared types and fixed-point constants for the sequential CNN MAC engine.
package cnn_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int A_W        = 14;
  localparam int B_W        = 7;
  localparam int P_W        = 21;
  localparam int FRAC_SHIFT = 7;
  localparam int OUT_MAX    = 8191;
  localparam int OUT_MIN    = -8192;

endpackage

// File: rtl/cnn_mac_seq_mul.sv
// Combinational signed Q6.8 activation times unsigned U0.7 weight, full 21-bit product.
module cnn_mac_seq_mul
  import cnn_mac_pkg::*;
(
  input  logic        [A_W-1:0] a,
  input  logic        [B_W-1:0] b,
  output logic signed [P_W-1:0] p
);

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;

  // Weight is zero-extended so it is never read as negative.
  assign a_ext = {{(P_W-A_W){a[A_W-1]}}, a};
  assign b_ext = {{(P_W-B_W){1'b0}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/cnn_mac_seq.sv
// Sequential dot-product engine: streams N activation/weight pairs from two ROMs,
// accumulates the products and returns a floor-shifted, saturated Q6.8 result.
module cnn_mac_seq
  import cnn_mac_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = 29
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] a_address0,
  output logic             a_ce0,
  input  logic [A_W-1:0]   a_q0,
  output logic [LEN_W-1:0] b_address0,
  output logic             b_ce0,
  input  logic [B_W-1:0]   b_q0,
  output logic [A_W-1:0]   ap_return,
  output logic             sat,
  output state_t           fsm_state
);

  // Handshake: ap_start is only looked at while ap_idle=1 (one-cycle acceptance);
  // ap_ready pulses when the last input address is issued, ap_done pulses once
  // when ap_return/sat are valid, and they stay valid until the next acceptance.

  localparam logic signed [ACC_W-1:0] MAX_A = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] MIN_A = ACC_W'(OUT_MIN);

  state_t                  state, state_nxt;
  logic        [LEN_W-1:0] n_q;
  logic        [LEN_W-1:0] cnt;
  logic                    drain_cnt;
  logic                    d_valid;
  logic                    p_valid;
  logic signed [P_W-1:0]   mul_p;
  logic signed [P_W-1:0]   prod_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic                    last_issue;
  logic                    accept;

  cnn_mac_seq_mul u_mul (
    .a (a_q0),
    .b (b_q0),
    .p (mul_p)
  );

  assign accept     = (state == IDLE) && ap_start;
  assign last_issue = (state == RUN) && (cnt == n_q - LEN_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ap_start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= IDLE;
      n_q       <= '0;
      cnt       <= '0;
      drain_cnt <= 1'b0;
      d_valid   <= 1'b0;
      p_valid   <= 1'b0;
      prod_q    <= '0;
      acc       <= '0;
    end else begin
      state     <= state_nxt;
      // ROM data lands one cycle after issue, product register one cycle later.
      d_valid   <= (state == RUN);
      p_valid   <= d_valid;
      prod_q    <= mul_p;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (accept) begin
        n_q <= len;
        cnt <= '0;
      end else if ((state == RUN) && !last_issue) begin
        cnt <= cnt + LEN_W'(1);
      end
      if (accept)
        acc <= '0;
      else if (p_valid)
        acc <= acc + {{(ACC_W-P_W){prod_q[P_W-1]}}, prod_q};
    end
  end

  assign shifted = acc >>> FRAC_SHIFT;

  always_comb begin
    sat       = 1'b0;
    ap_return = shifted[A_W-1:0];
    if (shifted > MAX_A) begin
      sat       = 1'b1;
      ap_return = A_W'(OUT_MAX);
    end else if (shifted < MIN_A) begin
      sat       = 1'b1;
      ap_return = A_W'(OUT_MIN);
    end
  end

  assign ap_idle    = (state == IDLE);
  assign ap_done    = (state == DONE);
  assign ap_ready   = last_issue || ((state == DONE) && (n_q == '0));
  assign a_ce0      = (state == RUN);
  assign b_ce0      = (state == RUN);
  assign a_address0 = (state == RUN) ? cnt : '0;
  assign b_address0 = (state == RUN) ? cnt : '0;
  assign fsm_state  = state;

endmodule

// File: tb/tb_cnn_mac_seq.sv
// Directed, table-driven bench for cnn_mac_seq with behavioural ROM models.
module tb_cnn_mac_seq;
  import cnn_mac_pkg::*;

  logic        ap_clk;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [7:0]  len;
  logic [7:0]  a_address0;
  logic        a_ce0;
  logic [13:0] a_q0;
  logic [7:0]  b_address0;
  logic        b_ce0;
  logic [6:0]  b_q0;
  logic [13:0] ap_return;
  logic        sat;
  state_t      fsm_state;

  logic [13:0] a_mem [256];
  logic [6:0]  b_mem [256];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int n;
    int a;
    int b;
    int ret;
    int sat;
    int rdy;
    int done;
  } vec_t;

  vec_t vecs [8];

  cnn_mac_seq dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .ap_ready   (ap_ready),
    .len        (len),
    .a_address0 (a_address0),
    .a_ce0      (a_ce0),
    .a_q0       (a_q0),
    .b_address0 (b_address0),
    .b_ce0      (b_ce0),
    .b_q0       (b_q0),
    .ap_return  (ap_return),
    .sat        (sat),
    .fsm_state  (fsm_state)
  );

  // Clock and ROM models (1-cycle read latency).
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    a_q0 = '0;
    b_q0 = '0;
  end

  always @(posedge ap_clk) begin
    if (a_ce0) a_q0 <= a_mem[a_address0];
    if (b_ce0) b_q0 <= b_mem[b_address0];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int a, input int b);
    for (int k = 0; k < 256; k++) begin
      a_mem[k] = 14'(a);
      b_mem[k] = 7'(b);
    end
  endtask

  // One operation: start at cycle 0, observe until ap_done, then one held cycle.
  task automatic run_op(input string name, input int n, input int pulse_cyc,
                        input int exp_ret, input int exp_sat,
                        input int exp_rdy, input int exp_done);
    int rdy_cyc, rdy_cnt, done_cyc, ce_cnt, addr_ok;
    rdy_cyc  = -1;
    rdy_cnt  = 0;
    done_cyc = -1;
    ce_cnt   = 0;
    addr_ok  = 1;
    @(negedge ap_clk);
    chk({name, "_idle0"}, int'(ap_idle), 1);
    ap_start = 1'b1;
    len      = 8'(n);
    for (int cyc = 1; cyc <= n + 12; cyc++) begin
      @(negedge ap_clk);
      ap_start = (cyc == pulse_cyc);
      if (pulse_cyc > 0 && cyc >= pulse_cyc) len = 8'd1;
      if (b_ce0 != a_ce0) addr_ok = 0;
      if (a_ce0) begin
        if (int'(a_address0) != ce_cnt || int'(b_address0) != ce_cnt) addr_ok = 0;
        ce_cnt++;
      end
      if (ap_ready) begin
        if (rdy_cyc < 0) rdy_cyc = cyc;
        rdy_cnt++;
      end
      if (ap_done) begin
        done_cyc = cyc;
        break;
      end
    end
    ap_start = 1'b0;
    chk({name, "_done_cyc"}, done_cyc, exp_done);
    chk({name, "_ready_cyc"}, rdy_cyc, exp_rdy);
    chk({name, "_ready_cnt"}, rdy_cnt, 1);
    chk({name, "_ce_cnt"}, ce_cnt, n);
    chk({name, "_addr_seq"}, addr_ok, 1);
    chk({name, "_ret"}, int'($signed(ap_return)), exp_ret);
    chk({name, "_sat"}, int'(sat), exp_sat);
    @(negedge ap_clk);
    chk({name, "_idle_after"}, int'(ap_idle), 1);
    chk({name, "_ret_held"}, int'($signed(ap_return)), exp_ret);
    chk({name, "_sat_held"}, int'(sat), exp_sat);
  endtask

  // Start an N=10 op and hit reset at rst_cyc; everything must be cleared next cycle.
  task automatic reset_mid(input string name, input int rst_cyc);
    @(negedge ap_clk);
    ap_start = 1'b1;
    len      = 8'd10;
    for (int cyc = 1; cyc <= rst_cyc; cyc++) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
    end
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk({name, "_idle"}, int'(ap_idle), 1);
    chk({name, "_ce"}, int'(a_ce0 | b_ce0), 0);
    chk({name, "_addr"}, int'(a_address0 | b_address0), 0);
    chk({name, "_ret"}, int'(ap_return), 0);
    chk({name, "_sat"}, int'(sat), 0);
    chk({name, "_done_ready"}, int'(ap_done | ap_ready), 0);
  endtask

  initial begin
    int done1, done2, idle6, ret1, ret2;
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    len      = '0;
    fill(0, 0);

    vecs[0] = '{n: 4,   a: 256,   b: 64,  ret: 512,   sat: 0, rdy: 4,   done: 7};
    vecs[1] = '{n: 0,   a: 0,     b: 0,   ret: 0,     sat: 0, rdy: 1,   done: 1};
    vecs[2] = '{n: 255, a: 8191,  b: 127, ret: 8191,  sat: 1, rdy: 255, done: 258};
    vecs[3] = '{n: 255, a: -8192, b: 127, ret: -8192, sat: 1, rdy: 255, done: 258};
    vecs[4] = '{n: 1,   a: -1,    b: 1,   ret: -1,    sat: 0, rdy: 1,   done: 4};
    vecs[5] = '{n: 1,   a: 1,     b: 1,   ret: 0,     sat: 0, rdy: 1,   done: 4};
    vecs[6] = '{n: 1,   a: 128,   b: 127, ret: 127,   sat: 0, rdy: 1,   done: 4};
    vecs[7] = '{n: 3,   a: -256,  b: 127, ret: -762,  sat: 0, rdy: 3,   done: 6};

    repeat (3) @(negedge ap_clk);
    chk("rst_idle", int'(ap_idle), 1);
    chk("rst_done_ready", int'(ap_done | ap_ready), 0);
    chk("rst_ce", int'(a_ce0 | b_ce0), 0);
    chk("rst_ret", int'(ap_return), 0);
    chk("rst_sat", int'(sat), 0);
    ap_rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      fill(vecs[i].a, vecs[i].b);
      run_op($sformatf("v%0d", i), vecs[i].n, -1, vecs[i].ret, vecs[i].sat,
             vecs[i].rdy, vecs[i].done);
    end

    // Per-address data: a = -200,-100,0,100,200 ; b = 1..5 -> sum 1000 -> 7.
    for (int k = 0; k < 5; k++) begin
      a_mem[k] = 14'(k * 100 - 200);
      b_mem[k] = 7'(k + 1);
    end
    run_op("ramp", 5, -1, 7, 0, 5, 8);

    // Start pulse and len change while running must not disturb the operation.
    fill(256, 64);
    run_op("pulse_run", 4, 2, 512, 0, 4, 7);

    fill(128, 127);
    reset_mid("rst_c3", 3);
    run_op("after_rst_c3", 1, -1, 127, 0, 1, 4);
    reset_mid("rst_c8", 8);
    run_op("after_rst_c8", 1, -1, 127, 0, 1, 4);

    // ap_start held high across two back-to-back N=2 operations.
    fill(256, 64);
    done1 = -1;
    done2 = -1;
    idle6 = 0;
    ret1  = 0;
    ret2  = 0;
    @(negedge ap_clk);
    ap_start = 1'b1;
    len      = 8'd2;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge ap_clk);
      if (cyc == 6) idle6 = int'(ap_idle);
      if (ap_done) begin
        if (done1 < 0) begin
          done1 = cyc;
          ret1  = int'($signed(ap_return));
        end else begin
          done2 = cyc;
          ret2  = int'($signed(ap_return));
          ap_start = 1'b0;
          break;
        end
      end
    end
    ap_start = 1'b0;
    chk("held_done1", done1, 5);
    chk("held_idle6", idle6, 1);
    chk("held_done2", done2, 11);
    chk("held_ret1", ret1, 256);
    chk("held_ret2", ret2, 256);
    @(negedge ap_clk);
    @(negedge ap_clk);
    chk("held_stop_idle", int'(ap_idle), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
